// File: rtl/bcd_entry_if.sv
// Handshake and data bundle between a controller and bcd_entry_sender.
interface bcd_entry_if;
    logic        start;
    logic [15:0] digits;
    logic [2:0]  count;
    logic        abort;
    logic [3:0]  input_data;
    logic        load;
    logic        busy;
    logic        done;
    logic        err;
    logic [1:0]  digit_idx;

    modport master (
        output start, digits, count, abort,
        input  input_data, load, busy, done, err, digit_idx
    );

    modport slave (
        input  start, digits, count, abort,
        output input_data, load, busy, done, err, digit_idx
    );
endinterface

// File: rtl/bcd_entry_sender.sv
// Sends up to four BCD digits, each held for a setup window, strobed by a
// one-cycle active-low load pulse, then held through a gap window.
module bcd_entry_sender #(
    parameter int SETUP_CYC = 4,
    parameter int GAP_CYC   = 10
) (
    input logic        clk,
    input logic        reset,
    bcd_entry_if.slave bus
);

    typedef enum logic [2:0] {IDLE, SETUP, PULSE, GAP, DONE} state_t;

    state_t      state_q, state_nx;
    logic [4:0]  cyc_q, cyc_nx;
    logic [1:0]  idx_q, idx_nx;
    logic [2:0]  left_q, left_nx;
    logic [11:0] sh_q, sh_nx;
    logic [3:0]  data_q, data_nx;
    logic        load_q, load_nx;
    logic        busy_q, busy_nx;
    logic        done_q, done_nx;
    logic        err_q, err_nx;

    function automatic logic req_ok(input logic [15:0] d, input logic [2:0] n);
        logic ok;
        ok = (n >= 3'd1) && (n <= 3'd4);
        for (int i = 0; i < 4; i++) begin
            if ((i < int'(n)) && (d[15-4*i -: 4] > 4'd9)) ok = 1'b0;
        end
        return ok;
    endfunction

    always_comb begin
        state_nx = state_q;
        cyc_nx   = cyc_q;
        idx_nx   = idx_q;
        left_nx  = left_q;
        sh_nx    = sh_q;
        data_nx  = data_q;
        load_nx  = 1'b1;
        busy_nx  = busy_q;
        done_nx  = 1'b0;
        err_nx   = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (req_ok(bus.digits, bus.count)) begin
                        state_nx = SETUP;
                        cyc_nx   = 5'd0;
                        idx_nx   = 2'd0;
                        left_nx  = bus.count - 3'd1;
                        sh_nx    = bus.digits[11:0];
                        data_nx  = bus.digits[15:12];
                        busy_nx  = 1'b1;
                    end else begin
                        err_nx = 1'b1;
                    end
                end
            end
            SETUP: begin
                if (cyc_q == 5'(SETUP_CYC - 1)) begin
                    state_nx = PULSE;
                    cyc_nx   = 5'd0;
                    load_nx  = 1'b0;
                end else begin
                    cyc_nx = cyc_q + 5'd1;
                end
            end
            PULSE: begin
                state_nx = GAP;
                cyc_nx   = 5'd0;
            end
            GAP: begin
                if (cyc_q == 5'(GAP_CYC - 1)) begin
                    cyc_nx = 5'd0;
                    if (left_q != 3'd0) begin
                        state_nx = SETUP;
                        idx_nx   = idx_q + 2'd1;
                        left_nx  = left_q - 3'd1;
                        data_nx  = sh_q[11:8];
                        sh_nx    = {sh_q[7:0], 4'h0};
                    end else begin
                        state_nx = DONE;
                        done_nx  = 1'b1;
                        busy_nx  = 1'b0;
                        data_nx  = 4'h0;
                        idx_nx   = 2'd0;
                    end
                end else begin
                    cyc_nx = cyc_q + 5'd1;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase

        // Abort overrides whatever transition the sequence would have taken.
        if (busy_q && bus.abort) begin
            state_nx = IDLE;
            cyc_nx   = 5'd0;
            idx_nx   = 2'd0;
            left_nx  = 3'd0;
            data_nx  = 4'h0;
            load_nx  = 1'b1;
            busy_nx  = 1'b0;
            done_nx  = 1'b0;
            err_nx   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cyc_q   <= 5'd0;
            idx_q   <= 2'd0;
            left_q  <= 3'd0;
            data_q  <= 4'h0;
            load_q  <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_nx;
            cyc_q   <= cyc_nx;
            idx_q   <= idx_nx;
            left_q  <= left_nx;
            data_q  <= data_nx;
            load_q  <= load_nx;
            busy_q  <= busy_nx;
            done_q  <= done_nx;
            err_q   <= err_nx;
        end
    end

    // Remaining captured nibbles are pure data; only read while busy.
    always_ff @(posedge clk) begin
        sh_q <= sh_nx;
    end

    assign bus.input_data = data_q;
    assign bus.load       = load_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.err        = err_q;
    assign bus.digit_idx  = idx_q;

endmodule

// File: tb/tb_bcd_entry_sender.sv
// Self-checking bench: per-cycle expectations derived from the digit timing
// arithmetic (period = setup + 1 + gap) for directed and random requests.
module tb_bcd_entry_sender;
    localparam int S = 4;
    localparam int G = 10;
    localparam int T = S + 1 + G;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   edge_n  = 0;
    int   n_checks = 0;
    int   n_fail   = 0;

    bcd_entry_if bus();

    bcd_entry_sender #(.SETUP_CYC(S), .GAP_CYC(G)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edge_n++;

    // Drives one request at the next edge k and checks every output each
    // cycle against the expected waveform computed from the timing rules.
    task automatic run_seq(input string tag, input logic [15:0] d, input int n,
                           input int abort_rel, input bit noise);
        bit   ok;
        int   k, abort_e, total, e, r, j;
        logic x_busy, x_load, x_done, x_err;
        logic [3:0] x_data;
        logic [1:0] x_idx;
        ok = (n >= 1) && (n <= 4);
        for (int i = 0; i < 4; i++)
            if (i < n && ((d >> (12 - 4*i)) & 16'hF) > 16'd9) ok = 1'b0;
        bus.start  = 1'b1;
        bus.digits = d;
        bus.count  = 3'(n);
        bus.abort  = 1'b0;
        k       = edge_n + 1;
        abort_e = (abort_rel > 0) ? k + abort_rel : 32'h3fffffff;
        total   = ok ? n*T + 3 : 3;
        for (int c = 0; c <= total; c++) begin
            @(negedge clk);
            e = edge_n;
            r = e - k;
            j = r / T;
            x_busy = ok && (r < n*T) && (e < abort_e);
            x_load = !(x_busy && (r % T) == S);
            x_data = x_busy ? 4'((d >> (12 - 4*j)) & 16'hF) : 4'h0;
            x_idx  = x_busy ? 2'(j) : 2'd0;
            x_done = ok && (r == n*T) && (e < abort_e);
            x_err  = !ok && (r == 0);
            n_checks += 6;
            if (bus.load !== x_load) begin
                n_fail++; $display("FAIL %s load r=%0d got %b want %b", tag, r, bus.load, x_load);
            end
            if (bus.busy !== x_busy) begin
                n_fail++; $display("FAIL %s busy r=%0d got %b want %b", tag, r, bus.busy, x_busy);
            end
            if (bus.input_data !== x_data) begin
                n_fail++; $display("FAIL %s input_data r=%0d got %h want %h", tag, r, bus.input_data, x_data);
            end
            if (bus.digit_idx !== x_idx) begin
                n_fail++; $display("FAIL %s digit_idx r=%0d got %0d want %0d", tag, r, bus.digit_idx, x_idx);
            end
            if (bus.done !== x_done) begin
                n_fail++; $display("FAIL %s done r=%0d got %b want %b", tag, r, bus.done, x_done);
            end
            if (bus.err !== x_err) begin
                n_fail++; $display("FAIL %s err r=%0d got %b want %b", tag, r, bus.err, x_err);
            end
            // Start is only toggled while the sender must ignore it.
            bus.start  = (noise && ok && (e + 1 > k) && (e + 1 <= k + n*T + 1) &&
                          (e + 1 <= abort_e)) ? 1'($urandom % 2) : 1'b0;
            bus.digits = 16'($urandom);
            bus.count  = 3'($urandom);
            bus.abort  = (e + 1 == abort_e);
        end
        bus.start = 1'b0;
        bus.abort = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_checks += 6;
        if (bus.load !== 1'b1)       begin n_fail++; $display("FAIL reset load got %b want 1", bus.load); end
        if (bus.busy !== 1'b0)       begin n_fail++; $display("FAIL reset busy got %b want 0", bus.busy); end
        if (bus.done !== 1'b0)       begin n_fail++; $display("FAIL reset done got %b want 0", bus.done); end
        if (bus.err !== 1'b0)        begin n_fail++; $display("FAIL reset err got %b want 0", bus.err); end
        if (bus.input_data !== 4'h0) begin n_fail++; $display("FAIL reset input_data got %h want 0", bus.input_data); end
        if (bus.digit_idx !== 2'd0)  begin n_fail++; $display("FAIL reset digit_idx got %0d want 0", bus.digit_idx); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_idle_abort();
        for (int i = 0; i < 4; i++) begin
            bus.abort = 1'($urandom % 2);
            @(negedge clk);
            n_checks += 2;
            if (bus.load !== 1'b1) begin n_fail++; $display("FAIL idle_abort load got %b want 1", bus.load); end
            if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL idle_abort busy got %b want 0", bus.busy); end
        end
        bus.abort = 1'b0;
    endtask

    task automatic test_invalid();
        run_seq("bad_nibble", 16'h4A00, 2, 0, 1'b0);
        run_seq("one_digit", 16'h4A00, 1, 0, 1'b0);
        run_seq("count0", 16'h1234, 0, 0, 1'b0);
        run_seq("count5", 16'h1234, 5, 0, 1'b0);
    endtask

    task automatic test_abort();
        run_seq("abort20", 16'h0123, 4, 20, 1'b0);
        run_seq("after_abort", 16'h5678, 3, 0, 1'b0);
    endtask

    task automatic test_reset_mid();
        bit seen = 1'b0;
        bus.start = 1'b1; bus.digits = 16'h9999; bus.count = 3'd4;
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 0; i < 3*T && !seen; i++) begin
            if (bus.load === 1'b0) seen = 1'b1;
            else @(negedge clk);
        end
        n_checks++;
        if (!seen) begin n_fail++; $display("FAIL reset_mid pulse never seen got 0 want 1"); end
        #1 reset = 1'b1;
        #1;
        n_checks += 3;
        if (bus.load !== 1'b1)       begin n_fail++; $display("FAIL reset_mid async load got %b want 1", bus.load); end
        if (bus.busy !== 1'b0)       begin n_fail++; $display("FAIL reset_mid async busy got %b want 0", bus.busy); end
        if (bus.input_data !== 4'h0) begin n_fail++; $display("FAIL reset_mid async data got %h want 0", bus.input_data); end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 2*T; i++) begin
            @(negedge clk);
            n_checks += 3;
            if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_mid done got %b want 0", bus.done); end
            if (bus.err !== 1'b0)  begin n_fail++; $display("FAIL reset_mid err got %b want 0", bus.err); end
            if (bus.load !== 1'b1) begin n_fail++; $display("FAIL reset_mid load got %b want 1", bus.load); end
        end
        run_seq("post_reset", 16'h2468, 4, 0, 1'b0);
    endtask

    task automatic test_random();
        logic [15:0] d;
        int n, ab;
        for (int it = 0; it < 16; it++) begin
            n = ($urandom % 4 == 0) ? int'($urandom_range(0, 5)) : int'($urandom_range(1, 4));
            for (int i = 0; i < 4; i++)
                d[15-4*i -: 4] = ($urandom % 8 == 0) ? 4'($urandom_range(10, 15))
                                                     : 4'($urandom_range(0, 9));
            ab = ($urandom % 3 == 0) ? int'($urandom_range(1, (n < 1 ? 1 : n)*T + 2)) : 0;
            run_seq("random", d, n, ab, 1'($urandom % 2));
        end
    endtask

    initial begin
        bus.start = 1'b0; bus.digits = 16'h0; bus.count = 3'd0; bus.abort = 1'b0;
        test_reset();
        test_idle_abort();
        run_seq("all_nines", 16'h9999, 4, 0, 1'b0);
        run_seq("ascending", 16'h0123, 4, 0, 1'b0);
        test_invalid();
        test_abort();
        run_seq("busy_start", 16'h7531, 4, 0, 1'b1);
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
